// File: rtl/mac_tx_pkg.sv
// Shared definitions for the MAC TX FIFO write-side arbiter: FSM encoding,
// FIFO word tag positions and default packet length limit.
package mac_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_MAX_PKT_WORDS = 1024;

  // FIFO word layout is {sop, eop, data}
  function automatic int sop_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int eop_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/mac_tx_fifo_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone eligible requester wins, a tie goes to the
// requester that did not own the previous grant.
module rr_arb2
  import mac_tx_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (eligible)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_grant ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mac_tx_fifo_arbiter.sv
// Packet-granular round-robin arbiter feeding the MAC TX FIFO write port,
// with almost_full throttling and forced truncation of over-long packets.
module mac_tx_fifo_arbiter
  import mac_tx_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int MAX_PKT_WORDS = DEFAULT_MAX_PKT_WORDS,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  wr_clk,
  input  logic                  ainit,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  input  logic                  req0_sop,
  input  logic                  req0_eop,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  input  logic                  req1_sop,
  input  logic                  req1_eop,
  output logic                  req1_ready,
  output logic [DATA_WIDTH+1:0] fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic [1:0]            grant,
  output logic                  trunc_pulse,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

  localparam int WCW     = $clog2(MAX_PKT_WORDS + 1);
  localparam int SOP_BIT = sop_bit(DATA_WIDTH);
  localparam int EOP_BIT = eop_bit(DATA_WIDTH);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(MAX_PKT_WORDS - 1);

  state_t                state_reg, state_next;
  logic [1:0]            grant_reg, grant_next;
  logic                  last_grant_reg, last_grant_next;
  logic [WCW-1:0]        word_cnt_reg, word_cnt_next;
  logic                  first_reg, first_next;
  logic [DATA_WIDTH+1:0] din_reg, din_next;
  logic                  wr_en_reg, wr_en_next;
  logic                  trunc_reg, trunc_next;
  logic [CNT_WIDTH-1:0]  cnt0_reg, cnt0_next;
  logic [CNT_WIDTH-1:0]  cnt1_reg, cnt1_next;

  logic                  owner;
  logic                  owner_valid;
  logic                  owner_eop;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [1:0]            eligible;
  logic [1:0]            pick;
  logic                  can_write;
  logic                  at_limit;
  logic [DATA_WIDTH+1:0] word_out;

  assign owner       = grant_reg[1];
  assign owner_valid = owner ? req1_valid : req0_valid;
  assign owner_eop   = owner ? req1_eop   : req0_eop;
  assign owner_data  = owner ? req1_data  : req0_data;
  assign eligible    = {req1_valid && req1_sop, req0_valid && req0_sop};
  assign can_write   = !fifo_almost_full && !fifo_full;
  assign at_limit    = (word_cnt_reg == LAST_WORD);

  rr_arb2 u_rr_arb2 (
    .eligible   (eligible),
    .last_grant (last_grant_reg),
    .pick       (pick)
  );

  // Source sop is ignored here: only the first word of a grant carries SOP.
  always_comb begin
    word_out                   = '0;
    word_out[DATA_WIDTH-1:0]   = owner_data;
    word_out[EOP_BIT]          = owner_eop || at_limit;
    word_out[SOP_BIT]          = first_reg;
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    word_cnt_next   = word_cnt_reg;
    first_next      = first_reg;
    din_next        = din_reg;
    wr_en_next      = 1'b0;
    trunc_next      = 1'b0;
    cnt0_next       = cnt0_reg;
    cnt1_next       = cnt1_reg;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Stray mid-packet words are swallowed while nobody owns the FIFO.
        req0_ready = req0_valid && !req0_sop;
        req1_ready = req1_valid && !req1_sop;
        if (pick != 2'b00) begin
          grant_next    = pick;
          state_next    = ST_XFER;
          word_cnt_next = '0;
          first_next    = 1'b1;
        end
      end

      ST_XFER: begin
        if (owner) req1_ready = can_write;
        else       req0_ready = can_write;
        if (owner_valid && can_write) begin
          wr_en_next    = 1'b1;
          din_next      = word_out;
          word_cnt_next = word_cnt_reg + 1'b1;
          first_next    = 1'b0;
          if (owner_eop || at_limit) begin
            if (owner) cnt1_next = cnt1_reg + 1'b1;
            else       cnt0_next = cnt0_reg + 1'b1;
            last_grant_next = owner;
            if (owner_eop) begin
              grant_next = 2'b00;
              state_next = ST_IDLE;
            end else begin
              trunc_next = 1'b1;
              state_next = ST_DROP;
            end
          end
        end
      end

      ST_DROP: begin
        if (owner) req1_ready = 1'b1;
        else       req0_ready = 1'b1;
        if (owner_valid && owner_eop) begin
          grant_next = 2'b00;
          state_next = ST_IDLE;
        end
      end

      default: begin
        grant_next = 2'b00;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge ainit) begin
    if (ainit) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 2'b00;
      last_grant_reg <= 1'b1;
      word_cnt_reg   <= '0;
      first_reg      <= 1'b0;
      din_reg        <= '0;
      wr_en_reg      <= 1'b0;
      trunc_reg      <= 1'b0;
      cnt0_reg       <= '0;
      cnt1_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      word_cnt_reg   <= word_cnt_next;
      first_reg      <= first_next;
      din_reg        <= din_next;
      wr_en_reg      <= wr_en_next;
      trunc_reg      <= trunc_next;
      cnt0_reg       <= cnt0_next;
      cnt1_reg       <= cnt1_next;
    end
  end

  assign fifo_din    = din_reg;
  assign fifo_wr_en  = wr_en_reg;
  assign grant       = grant_reg;
  assign trunc_pulse = trunc_reg;
  assign pkt_cnt0    = cnt0_reg;
  assign pkt_cnt1    = cnt1_reg;

endmodule

// File: tb/tb_mac_tx_fifo_arbiter.sv
// Directed bench for mac_tx_fifo_arbiter with hand-computed expected FIFO
// words, grants, pulses and packet counts.
module tb_mac_tx_fifo_arbiter;

  logic        wr_clk = 1'b0;
  logic        ainit;
  logic [15:0] req0_data, req1_data;
  logic        req0_valid, req0_sop, req0_eop, req0_ready;
  logic        req1_valid, req1_sop, req1_eop, req1_ready;
  logic [17:0] fifo_din;
  logic        fifo_wr_en, fifo_full, fifo_almost_full;
  logic [1:0]  grant;
  logic        trunc_pulse;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 wr_clk = ~wr_clk;

  mac_tx_fifo_arbiter #(.DATA_WIDTH(16), .MAX_PKT_WORDS(8), .CNT_WIDTH(16)) dut (
    .wr_clk           (wr_clk),
    .ainit            (ainit),
    .req0_data        (req0_data),
    .req0_valid       (req0_valid),
    .req0_sop         (req0_sop),
    .req0_eop         (req0_eop),
    .req0_ready       (req0_ready),
    .req1_data        (req1_data),
    .req1_valid       (req1_valid),
    .req1_sop         (req1_sop),
    .req1_eop         (req1_eop),
    .req1_ready       (req1_ready),
    .fifo_din         (fifo_din),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .grant            (grant),
    .trunc_pulse      (trunc_pulse),
    .pkt_cnt0         (pkt_cnt0),
    .pkt_cnt1         (pkt_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic [15:0] d,
                       input logic s, input logic e);
    if (r == 0) begin
      req0_valid = v; req0_data = d; req0_sop = s; req0_eop = e;
    end else begin
      req1_valid = v; req1_data = d; req1_sop = s; req1_eop = e;
    end
  endtask

  task automatic pend(input int r, input logic [15:0] d);
    drive(r, 1'b1, d, 1'b1, 1'b0);
  endtask

  // Present one word, wait (bounded) for ready, clock it in, check the result.
  task automatic xfer(input int r, input logic [15:0] d, input logic s, input logic e,
                      input logic exp_wr, input logic exp_tr, input logic [1:0] exp_g,
                      input logic [17:0] exp_din);
    int n;
    n = 0;
    drive(r, 1'b1, d, s, e);
    #1;
    while (((r == 0) ? req0_ready : req1_ready) == 1'b0 && n < 20) begin
      @(posedge wr_clk); #1;
      n++;
    end
    chk("ready_timeout", 32'(n < 20), 32'd1);
    chk("grant", 32'(grant), 32'(exp_g));
    chk("other_ready", 32'((r == 0) ? req1_ready : req0_ready), 32'd0);
    @(posedge wr_clk); #1;
    drive(r, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    if (exp_wr) chk("din", 32'(fifo_din), 32'(exp_din));
    chk("trunc", 32'(trunc_pulse), 32'(exp_tr));
    $display("xfer r=%0d data=%h wr_en=%0b din=%h grant=%b trunc=%0b",
             r, d, fifo_wr_en, fifo_din, grant, trunc_pulse);
  endtask

  task automatic send_pkt(input int r, input logic [15:0] base, input int n,
                          input logic [1:0] exp_g);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 16'(i);
      xfer(r, d, i == 0, i == n - 1, 1'b1, 1'b0, exp_g, {i == 0, i == n - 1, d});
    end
  endtask

  task automatic pulse_reset();
    ainit = 1'b1;
    @(posedge wr_clk); #1;
    ainit = 1'b0;
    @(posedge wr_clk); #1;
  endtask

  initial begin
    logic [15:0] d;
    ainit = 1'b1;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge wr_clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_trunc", 32'(trunc_pulse), 32'd0);
    chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
    chk("rst_cnt1", 32'(pkt_cnt1), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    ainit = 1'b0;
    @(posedge wr_clk); #1;

    // Single 4-word packet from requester 0
    send_pkt(0, 16'hA001, 4, 2'b01);
    chk("t1_grant_idle", 32'(grant), 32'd0);
    chk("t1_cnt0", 32'(pkt_cnt0), 32'd1);

    // Simultaneous SOPs: grants alternate starting with requester 0
    pulse_reset();
    pend(1, 16'hB000);
    send_pkt(0, 16'hA000, 2, 2'b01);
    pend(0, 16'hA100);
    send_pkt(1, 16'hB000, 2, 2'b10);
    pend(1, 16'hB100);
    send_pkt(0, 16'hA100, 2, 2'b01);
    pend(0, 16'hA200);
    send_pkt(1, 16'hB100, 2, 2'b10);
    pend(1, 16'hB200);
    send_pkt(0, 16'hA200, 2, 2'b01);
    send_pkt(1, 16'hB200, 2, 2'b10);
    chk("t2_cnt0", 32'(pkt_cnt0), 32'd3);
    chk("t2_cnt1", 32'(pkt_cnt1), 32'd3);

    // almost_full stall for 5 cycles mid-packet; a stray source sop mid-packet
    xfer(0, 16'h3000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, {2'b10, 16'h3000});
    xfer(0, 16'h3001, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, {2'b00, 16'h3001});
    fifo_almost_full = 1'b1;
    drive(0, 1'b1, 16'h3002, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_ready", 32'(req0_ready), 32'd0);
      @(posedge wr_clk); #1;
      chk("t3_stall_wr_en", 32'(fifo_wr_en), 32'd0);
    end
    fifo_almost_full = 1'b0;
    xfer(0, 16'h3002, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, {2'b00, 16'h3002});
    xfer(0, 16'h3003, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, {2'b00, 16'h3003});
    xfer(0, 16'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, {2'b00, 16'h3004});
    xfer(0, 16'h3005, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, {2'b01, 16'h3005});
    chk("t3_cnt0", 32'(pkt_cnt0), 32'd4);

    // 12-word packet from requester 1 truncated at 8 words
    for (int i = 0; i < 12; i++) begin
      d = 16'hC000 + 16'(i);
      if (i < 8)
        xfer(1, d, i == 0, 1'b0, 1'b1, i == 7, 2'b10, {i == 0, i == 7, d});
      else
        xfer(1, d, 1'b0, i == 11, 1'b0, 1'b0, 2'b10, 18'h0);
    end
    chk("t4_grant_idle", 32'(grant), 32'd0);
    chk("t4_cnt1", 32'(pkt_cnt1), 32'd4);
    send_pkt(0, 16'hD000, 2, 2'b01);
    chk("t4_cnt0", 32'(pkt_cnt0), 32'd5);

    // Asynchronous reset on word 3 of a 6-word packet
    xfer(0, 16'hE000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, {2'b10, 16'hE000});
    xfer(0, 16'hE001, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, {2'b00, 16'hE001});
    drive(0, 1'b1, 16'hE002, 1'b0, 1'b0);
    #2;
    ainit = 1'b1;
    #1;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t5_cnt0", 32'(pkt_cnt0), 32'd0);
    chk("t5_cnt1", 32'(pkt_cnt1), 32'd0);
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge wr_clk); #1;
    ainit = 1'b0;
    @(posedge wr_clk); #1;
    pend(1, 16'hF000);
    send_pkt(0, 16'hE100, 2, 2'b01);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("t5_cnt0_after", 32'(pkt_cnt0), 32'd1);

    // Non-SOP words in IDLE are consumed without writes
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'b1, 16'h9990 + 16'(i), 1'b0, i == 1);
      #1;
      chk("t6_idle_ready", 32'(req1_ready), 32'd1);
      @(posedge wr_clk); #1;
      drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("t6_idle_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("t6_idle_grant", 32'(grant), 32'd0);
      $display("idle discard r=1 word=%0d wr_en=%0b grant=%b", i, fifo_wr_en, grant);
    end
    send_pkt(1, 16'h7000, 3, 2'b10);
    chk("t6_cnt1", 32'(pkt_cnt1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
